layered_palette_mixer: RTL and testbench

//  Per-pixel colour stage between sprite fetch and VGA output. Takes one palette index per sprite

---
 rtl/layered_palette_mixer_pkg.sv | 45 ++++
 rtl/layered_palette_mixer_palette_bank.sv | 47 ++++
 rtl/layered_palette_mixer.sv | 118 +++++++++++
 tb/tb_layered_palette_mixer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/layered_palette_mixer_pkg.sv
// Shared constants and {r,g,b} pack/unpack helpers for the layered palette mixer.
// Helpers take the channel width as an argument so any CBITS up to MAX_CBITS is served.
package layered_palette_mixer_pkg;

  localparam int DEF_CBITS = 3;
  localparam int MAX_CBITS = 8;
  localparam int MAX_RGB   = 3 * MAX_CBITS;

  typedef enum logic [1:0] {
    BLACK = 2'd0,
    PINK  = 2'd1,
    WHITE = 2'd2,
    GREEN = 2'd3
  } colour_e;

  function automatic logic [MAX_CBITS-1:0] chan_max(input int cbits);
    return MAX_CBITS'((32'd1 << cbits) - 32'd1);
  endfunction

  function automatic logic [MAX_RGB-1:0] pack_rgb(input int cbits,
                                                  input logic [MAX_CBITS-1:0] r,
                                                  input logic [MAX_CBITS-1:0] g,
                                                  input logic [MAX_CBITS-1:0] b);
    return (MAX_RGB'(r) << (2 * cbits)) | (MAX_RGB'(g) << cbits) | MAX_RGB'(b);
  endfunction

  // sel: 2 = red, 1 = green, 0 = blue
  function automatic logic [MAX_CBITS-1:0] rgb_chan(input int cbits,
                                                    input logic [MAX_RGB-1:0] rgb,
                                                    input int sel);
    return MAX_CBITS'(rgb >> (sel * cbits)) & chan_max(cbits);
  endfunction

  function automatic logic [MAX_RGB-1:0] default_rgb(input int cbits, input colour_e c);
    logic [MAX_CBITS-1:0] mx;
    mx = chan_max(cbits);
    case (c)
      PINK:    return pack_rgb(cbits, mx, {MAX_CBITS{1'b0}}, mx);
      WHITE:   return pack_rgb(cbits, mx, mx, mx);
      GREEN:   return pack_rgb(cbits, {MAX_CBITS{1'b0}}, mx, {MAX_CBITS{1'b0}});
      default: return {MAX_RGB{1'b0}};
    endcase
  endfunction

endpackage

// File: rtl/layered_palette_mixer_palette_bank.sv
// One layer's palette: register file with one write port and a registered read port.
// A read in the same cycle as a write to that entry returns the old contents.
module layered_palette_mixer_palette_bank
  import layered_palette_mixer_pkg::*;
#(
  parameter int PIX_BITS = 2,
  parameter int CBITS    = DEF_CBITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [PIX_BITS-1:0]  wr_idx,
  input  logic [3*CBITS-1:0]   wr_rgb,
  input  logic [PIX_BITS-1:0]  rd_idx,
  output logic [3*CBITS-1:0]   rd_rgb
);

  localparam int DEPTH = 2 ** PIX_BITS;
  localparam int RGB_W = 3 * CBITS;

  logic [RGB_W-1:0] mem_r [DEPTH];

  function automatic logic [RGB_W-1:0] reset_entry(input int idx);
    case (idx)
      1:       return RGB_W'(default_rgb(CBITS, PINK));
      2:       return RGB_W'(default_rgb(CBITS, WHITE));
      3:       return RGB_W'(default_rgb(CBITS, GREEN));
      default: return RGB_W'(default_rgb(CBITS, BLACK));
    endcase
  endfunction

  // Palette storage and read register; reset reloads the default palette.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= reset_entry(i);
      end
      rd_rgb <= {RGB_W{1'b0}};
    end else begin
      if (wr_en) begin
        mem_r[wr_idx] <= wr_rgb;
      end
      rd_rgb <= mem_r[rd_idx];
    end
  end

endmodule

// File: rtl/layered_palette_mixer.sv
// Two-stage pixel colour stage: per-layer palette lookup with opacity, then priority
// resolve to registered 3-channel RGB. Blink phase gates masked layers.
module layered_palette_mixer
  import layered_palette_mixer_pkg::*;
#(
  parameter int PIX_BITS     = 2,
  parameter int LAYERS       = 3,
  parameter int CBITS        = DEF_CBITS,
  parameter int BLINK_FRAMES = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_valid,
  input  logic [LAYERS*PIX_BITS-1:0]    i_pixel,
  input  logic                          i_frame_start,
  input  logic [LAYERS-1:0]             i_blink_mask,
  input  logic                          i_wr_en,
  input  logic [$clog2(LAYERS)-1:0]     i_wr_layer,
  input  logic [PIX_BITS-1:0]           i_wr_idx,
  input  logic [3*CBITS-1:0]            i_wr_rgb,
  output logic                          o_valid,
  output logic [CBITS-1:0]              o_r,
  output logic [CBITS-1:0]              o_g,
  output logic [CBITS-1:0]              o_b,
  output logic [$clog2(LAYERS)-1:0]     o_layer
);

  localparam int LW    = $clog2(LAYERS);
  localparam int RGB_W = 3 * CBITS;

  logic [7:0]        blink_cnt_r;
  logic              phase_r;
  logic              valid1_r;
  logic [LAYERS-1:0] opaque_r;
  logic [LAYERS-1:0] opaque_s;
  logic [RGB_W-1:0]  layer_rgb_s [LAYERS];
  logic [LW-1:0]     win_layer_s;
  logic [RGB_W-1:0]  win_rgb_s;

  for (genvar l = 0; l < LAYERS; l++) begin : g_layer
    layered_palette_mixer_palette_bank #(
      .PIX_BITS (PIX_BITS),
      .CBITS    (CBITS)
    ) u_bank (
      .clk    (clk),
      .rst    (rst),
      .wr_en  (i_wr_en && (i_wr_layer == LW'(l))),
      .wr_idx (i_wr_idx),
      .wr_rgb (i_wr_rgb),
      .rd_idx (i_pixel[l*PIX_BITS +: PIX_BITS]),
      .rd_rgb (layer_rgb_s[l])
    );

    // The background layer is the fallback and can never go transparent.
    if (l == LAYERS - 1) begin : g_bg
      assign opaque_s[l] = 1'b1;
    end else begin : g_fg
      assign opaque_s[l] = (i_pixel[l*PIX_BITS +: PIX_BITS] != {PIX_BITS{1'b0}}) &&
                           !(phase_r && i_blink_mask[l]);
    end
  end

  // Blink timer: phase flips every BLINK_FRAMES frame pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt_r <= 8'd0;
      phase_r     <= 1'b0;
    end else if (i_frame_start) begin
      if (blink_cnt_r == 8'(BLINK_FRAMES - 1)) begin
        blink_cnt_r <= 8'd0;
        phase_r     <= ~phase_r;
      end else begin
        blink_cnt_r <= blink_cnt_r + 8'd1;
      end
    end
  end

  // Stage 1 control: valid and per-layer opacity travel with the palette reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid1_r <= 1'b0;
      opaque_r <= {LAYERS{1'b0}};
    end else begin
      valid1_r <= i_valid;
      opaque_r <= opaque_s;
    end
  end

  // Priority resolve: scan from background upward so the lowest opaque layer wins.
  always_comb begin
    win_layer_s = LW'(LAYERS - 1);
    win_rgb_s   = layer_rgb_s[LAYERS-1];
    for (int l = LAYERS - 2; l >= 0; l--) begin
      win_layer_s = opaque_r[l] ? LW'(l) : win_layer_s;
      win_rgb_s   = opaque_r[l] ? layer_rgb_s[l] : win_rgb_s;
    end
  end

  // Output registers; colour holds between pixels while o_valid is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_valid <= 1'b0;
      o_r     <= {CBITS{1'b0}};
      o_g     <= {CBITS{1'b0}};
      o_b     <= {CBITS{1'b0}};
      o_layer <= {LW{1'b0}};
    end else begin
      o_valid <= valid1_r;
      if (valid1_r) begin
        o_r     <= CBITS'(rgb_chan(CBITS, MAX_RGB'(win_rgb_s), 2));
        o_g     <= CBITS'(rgb_chan(CBITS, MAX_RGB'(win_rgb_s), 1));
        o_b     <= CBITS'(rgb_chan(CBITS, MAX_RGB'(win_rgb_s), 0));
        o_layer <= win_layer_s;
      end
    end
  end

endmodule

// File: tb/tb_layered_palette_mixer.sv
// Scoreboard bench for layered_palette_mixer: a reference palette/blink model predicts
// each pixel's colour and arrival cycle; outputs are compared every cycle.
module tb_layered_palette_mixer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_valid = 1'b0;
  logic [5:0] i_pixel = 6'd0;
  logic       i_frame_start = 1'b0;
  logic [2:0] i_blink_mask = 3'd0;
  logic       i_wr_en = 1'b0;
  logic [1:0] i_wr_layer = 2'd0;
  logic [1:0] i_wr_idx = 2'd0;
  logic [8:0] i_wr_rgb = 9'd0;
  logic       o_valid;
  logic [2:0] o_r, o_g, o_b;
  logic [1:0] o_layer;

  layered_palette_mixer #(
    .PIX_BITS(2), .LAYERS(3), .CBITS(3), .BLINK_FRAMES(2)
  ) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_pixel(i_pixel),
    .i_frame_start(i_frame_start), .i_blink_mask(i_blink_mask),
    .i_wr_en(i_wr_en), .i_wr_layer(i_wr_layer), .i_wr_idx(i_wr_idx), .i_wr_rgb(i_wr_rgb),
    .o_valid(o_valid), .o_r(o_r), .o_g(o_g), .o_b(o_b), .o_layer(o_layer)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic [8:0] rgb;
    logic [1:0] layer;
  } exp_t;

  exp_t       sbq[$];
  logic [8:0] pal [3][4];
  int         cnt;
  logic       phase;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_errors = 0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int l = 0; l < 3; l++) begin
      pal[l][0] = 9'o000;
      pal[l][1] = 9'o707;
      pal[l][2] = 9'o777;
      pal[l][3] = 9'o070;
    end
    cnt   = 0;
    phase = 1'b0;
  endtask

  task automatic tick();
    exp_t e;
    logic exp_v;
    @(posedge clk);
    #1;
    cyc++;
    exp_v = (sbq.size() > 0) && (sbq[0].due == cyc);
    check_value("o_valid", {31'd0, o_valid}, {31'd0, exp_v});
    if (exp_v) begin
      e = sbq.pop_front();
      check_value("rgb", {23'd0, o_r, o_g, o_b}, {23'd0, e.rgb});
      check_value("o_layer", {30'd0, o_layer}, {30'd0, e.layer});
    end
  endtask

  task automatic apply(input logic v, input logic [5:0] pix, input logic [2:0] mask,
                       input logic fs, input logic we, input logic [1:0] wl,
                       input logic [1:0] wi, input logic [8:0] wrgb);
    exp_t e;
    logic [1:0] idx;
    i_valid = v; i_pixel = pix; i_blink_mask = mask; i_frame_start = fs;
    i_wr_en = we; i_wr_layer = wl; i_wr_idx = wi; i_wr_rgb = wrgb;
    if (!rst) begin
      if (v) begin
        e.due   = cyc + 2;
        e.layer = 2'd2;
        e.rgb   = pal[2][pix[5:4]];
        for (int l = 1; l >= 0; l--) begin
          idx = pix[l*2 +: 2];
          if (idx != 2'd0 && !(phase && mask[l])) begin
            e.layer = 2'(l);
            e.rgb   = pal[l][idx];
          end
        end
        sbq.push_back(e);
      end
      if (we && wl < 2'd3) pal[wl][wi] = wrgb;
      if (fs) begin
        if (cnt == 1) begin
          cnt   = 0;
          phase = ~phase;
        end else begin
          cnt++;
        end
      end
    end
    tick();
  endtask

  task automatic pix(input logic [5:0] p, input logic [2:0] mask);
    apply(1'b1, p, mask, 1'b0, 1'b0, 2'd0, 2'd0, 9'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply(1'b0, 6'd0, 3'd0, 1'b0, 1'b0, 2'd0, 2'd0, 9'd0);
  endtask

  task automatic frame();
    apply(1'b0, 6'd0, 3'd0, 1'b1, 1'b0, 2'd0, 2'd0, 9'd0);
  endtask

  initial begin
    model_reset();
    tick();
    tick();
    check_value("reset_o_valid", {31'd0, o_valid}, 32'd0);
    check_value("reset_rgb", {23'd0, o_r, o_g, o_b}, 32'd0);
    check_value("reset_layer", {30'd0, o_layer}, 32'd0);
    rst = 1'b0;

    // all layers idx 0 -> background black
    pix(6'b00_00_00, 3'b000);
    idle(3);

    // layer1 white shows through transparent layer0; then layer0 pink on top
    pix(6'b00_10_00, 3'b000);
    pix(6'b00_10_01, 3'b000);
    pix(6'b11_00_00, 3'b000);
    idle(3);

    // write layer1 idx2 with a same-cycle read, then read it back
    apply(1'b1, 6'b00_10_00, 3'b000, 1'b0, 1'b1, 2'd1, 2'd2, 9'o531);
    pix(6'b00_10_00, 3'b000);
    idle(3);

    // blink: layer0 masked, hidden after two frames, back after two more
    pix(6'b00_10_01, 3'b001);
    frame();
    frame();
    pix(6'b00_10_01, 3'b001);
    pix(6'b00_10_01, 3'b100);
    frame();
    apply(1'b1, 6'b00_10_01, 3'b001, 1'b1, 1'b0, 2'd0, 2'd0, 9'd0);
    pix(6'b00_10_01, 3'b001);
    idle(3);

    // out-of-range layer write must not touch any palette
    apply(1'b0, 6'd0, 3'd0, 1'b0, 1'b1, 2'd3, 2'd1, 9'o123);
    pix(6'b01_01_01, 3'b000);
    pix(6'b01_01_00, 3'b000);
    pix(6'b01_00_00, 3'b000);
    idle(3);

    // random traffic with writes, frames and masks
    for (int i = 0; i < 120; i++) begin
      apply(1'($urandom_range(0, 3) != 0), 6'($urandom), 3'($urandom),
            1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 3) == 0),
            2'($urandom), 2'($urandom), 9'($urandom));
    end

    // reset in the middle of a stream
    pix(6'b00_10_01, 3'b000);
    pix(6'b00_10_00, 3'b000);
    rst = 1'b1;
    #1;
    check_value("midrst_o_valid", {31'd0, o_valid}, 32'd0);
    check_value("midrst_rgb", {23'd0, o_r, o_g, o_b}, 32'd0);
    check_value("midrst_layer", {30'd0, o_layer}, 32'd0);
    sbq.delete();
    model_reset();
    pix(6'b00_10_00, 3'b000);
    pix(6'b00_10_00, 3'b000);
    rst = 1'b0;
    pix(6'b00_10_00, 3'b000);
    pix(6'b11_10_00, 3'b000);
    pix(6'b11_11_11, 3'b000);

    for (int i = 0; i < 10 && sbq.size() > 0; i++) idle(1);
    check_value("drain", sbq.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
